// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Width helpers let each module size its counters from its own parameters.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int BAUD_W           = $clog2(DEF_CLKS_PER_BIT);
    localparam int BIT_W            = $clog2(DEF_DATA_WIDTH + 1);

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    function automatic int baud_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

    function automatic int bit_cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags the
// terminal count; clear realigns the period to the start of a frame.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);

    localparam int             W  = baud_width(CLKS_PER_BIT);
    localparam logic [W-1:0]   TC = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == TC) ? '0 : r_cnt + 1'b1;
        end
    end

    assign bit_tick = run && (r_cnt == TC);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops words from a FIFO read port and sends each as a UART frame
// (start, data LSB-first, optional parity, 1-2 stop bits).
//
// state  | meaning
// IDLE   | line high, waiting for tx_enable and a non-empty FIFO
// POP    | one-cycle read strobe to the FIFO
// LOAD   | FIFO data valid: capture word and parity, align baud timer
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PARITY_EN=1)
// STOP   | stop bit(s); chain straight into the next pop if allowed
module uart_tx_fifo_drain
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int              BW        = bit_cnt_width(DATA_WIDTH);
    localparam logic [BW-1:0]   LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]   LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic            ODD_SEL   = (PARITY_ODD != uart_tx_pkg::PARITY_EVEN);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_parity;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_rd_en;
    logic                  r_tx;
    logic                  r_busy;

    logic w_bit_tick;
    logic w_baud_clear;
    logic w_baud_run;
    logic w_start_ok;

    assign w_baud_clear = (r_state == LOAD);
    assign w_baud_run   = (r_state inside {START, DATA, PARITY, STOP});
    assign w_start_ok   = tx_enable && !fifo_empty;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_baud_clear),
        .run      (w_baud_run),
        .bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_rd_en   <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_start_ok) begin
                        r_state <= POP;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                POP: r_state <= LOAD;
                LOAD: begin
                    r_shreg  <= fifo_data;
                    r_parity <= (^fifo_data) ^ ODD_SEL;
                    r_tx     <= 1'b0;
                    r_state  <= START;
                end
                START: if (w_bit_tick) begin
                    r_tx      <= r_shreg[0];
                    r_shreg   <= r_shreg >> 1;
                    r_bit_cnt <= '0;
                    r_state   <= DATA;
                end
                DATA: if (w_bit_tick) begin
                    if (r_bit_cnt == LAST_DATA) begin
                        r_bit_cnt <= '0;
                        if (PARITY_EN != 0) begin
                            r_tx    <= r_parity;
                            r_state <= PARITY;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end
                    end else begin
                        r_tx      <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                PARITY: if (w_bit_tick) begin
                    r_tx    <= 1'b1;
                    r_state <= STOP;
                end
                STOP: if (w_bit_tick) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        r_bit_cnt <= '0;
                        // Chaining directly into POP keeps the gap at exactly two cycles.
                        if (w_start_ok) begin
                            r_state <= POP;
                            r_rd_en <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Decoded from registers only, so it lands in the last stop-bit cycle.
    assign frame_done = (r_state == STOP) && w_bit_tick && (r_bit_cnt == LAST_STOP);

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: a FIFO model queues each popped word as an expected frame;
// a line monitor decodes tx cycle-by-cycle against it. Three parameter sets.
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic [1:0] sel   = 2'd0;
    logic [7:0] fdata = 8'h00;
    logic       fempty;

    logic [7:0] fmem [16];
    int         wp = 0;
    int         rp = 0;

    logic [2:0] w_rd, w_tx, w_busy, w_done;
    logic       m_rd, m_tx, m_busy, m_done;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int rd_cnt = 0, n_starts = 0, n_frames = 0, n_done = 0;
    int last_rd_cyc = -100, last_start_cyc = 0, last_end_cyc = -100, last_done_cyc = 0;
    int last_gap = -1;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fempty = (wp == rp);
    assign m_rd   = w_rd[sel];
    assign m_tx   = w_tx[sel];
    assign m_busy = w_busy[sel];
    assign m_done = w_done[sel];

    // 0: no parity, 1 stop   1: even parity, 1 stop   2: no parity, 2 stops
    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_enable(en), .fifo_empty(fempty), .fifo_data(fdata),
        .fifo_rd_en(w_rd[0]), .tx(w_tx[0]), .busy(w_busy[0]), .frame_done(w_done[0]));
    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_enable(en), .fifo_empty(fempty), .fifo_data(fdata),
        .fifo_rd_en(w_rd[1]), .tx(w_tx[1]), .busy(w_busy[1]), .frame_done(w_done[1]));
    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_enable(en), .fifo_empty(fempty), .fifo_data(fdata),
        .fifo_rd_en(w_rd[2]), .tx(w_tx[2]), .busy(w_busy[2]), .frame_done(w_done[2]));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO read port: data appears the cycle after the pop; the popped word becomes an expected frame
    always @(posedge clk) begin
        if (m_rd && (wp != rp)) begin
            fdata <= fmem[rp % 16];
            exp_q.push_back(fmem[rp % 16]);
            rp <= rp + 1;
        end
    end

    // Line monitor
    initial begin : monitor
        logic        in_frame;
        logic        prev_rd;
        logic [15:0] fb;
        logic [7:0]  d;
        int          t, total, nb;
        in_frame = 1'b0;
        prev_rd  = 1'b0;
        fb = '1; t = 0; total = 0; nb = 0; d = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                prev_rd  = 1'b0;
                chk("rst_tx", int'(m_tx), 1);
                chk("rst_busy", int'(m_busy), 0);
                chk("rst_rd_en", int'(m_rd), 0);
            end else begin
                if (m_rd) begin
                    rd_cnt++;
                    chk("rd_en_consecutive", int'(prev_rd), 0);
                    chk("rd_en_while_empty", int'(fempty), 0);
                    last_rd_cyc = cyc;
                end
                prev_rd = m_rd;
                if (m_done) begin
                    n_done++;
                    last_done_cyc = cyc;
                end
                if (!in_frame && m_tx == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got start bit expected none (t=%0t)", $time);
                        d = 8'h00;
                    end else begin
                        d = exp_q.pop_front();
                    end
                    fb = '1;
                    fb[0] = 1'b0;
                    for (int i = 0; i < 8; i++) fb[1+i] = d[i];
                    nb = 9;
                    if (sel == 2'd1) begin
                        fb[9] = ^d;
                        nb = 10;
                    end
                    nb += (sel == 2'd2) ? 2 : 1;
                    total = nb * CPB;
                    in_frame = 1'b1;
                    t = 0;
                    n_starts++;
                    chk("pop_to_start_latency", cyc - last_rd_cyc, 2);
                    last_gap = cyc - last_end_cyc - 1;
                    last_start_cyc = cyc;
                end
                if (in_frame) begin
                    chk("tx_bit", int'(m_tx), int'(fb[t / CPB]));
                    chk("frame_done_timing", int'(m_done), (t == total - 1) ? 1 : 0);
                    chk("busy_in_frame", int'(m_busy), 1);
                    if (t == total - 1) begin
                        in_frame = 1'b0;
                        n_frames++;
                        last_end_cyc = cyc;
                    end
                    t++;
                end else begin
                    chk("frame_done_idle", int'(m_done), 0);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] v);
        fmem[wp % 16] = v;
        wp++;
    endtask

    task automatic do_reset(input logic [1:0] s);
        en    = 1'b0;
        rst_n = 1'b0;
        sel   = s;
        step(3);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic wait_frames(input int target);
        int b = 0;
        while (n_frames < target && b < 2000) begin
            @(negedge clk);
            #1;
            b++;
        end
        chk("frame_wait_timeout", (n_frames >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_starts(input int target);
        int b = 0;
        while (n_starts < target && b < 2000) begin
            @(negedge clk);
            #1;
            b++;
        end
        chk("start_wait_timeout", (n_starts >= target) ? 1 : 0, 1);
    endtask

    initial begin : stim
        int r0, f0, s0, d0;

        // 1: reset with an empty FIFO
        #3 rst_n = 1'b0;
        sel = 2'd0;
        en  = 1'b1;
        step(3);
        chk("t1_tx_in_reset", int'(m_tx), 1);
        chk("t1_busy_in_reset", int'(m_busy), 0);
        chk("t1_rd_in_reset", int'(m_rd), 0);
        rst_n = 1'b1;
        step(50);
        chk("t1_no_rd_50", rd_cnt, 0);
        chk("t1_busy_idle", int'(m_busy), 0);
        chk("t1_tx_idle", int'(m_tx), 1);

        // 2: single frame 8'hA5
        r0 = rd_cnt; f0 = n_frames;
        push(8'hA5);
        wait_frames(f0 + 1);
        chk("t2_done_after_start", last_done_cyc - last_start_cyc, 39);
        step(5);
        chk("t2_rd_pulses", rd_cnt - r0, 1);
        chk("t2_busy_after", int'(m_busy), 0);

        // 3: back-to-back with even parity
        do_reset(2'd1);
        r0 = rd_cnt; f0 = n_frames;
        push(8'h01);
        push(8'h03);
        en = 1'b1;
        wait_frames(f0 + 2);
        chk("t3_gap", last_gap, 2);
        step(10);
        chk("t3_rd_pulses", rd_cnt - r0, 2);
        chk("t3_busy_after", int'(m_busy), 0);
        chk("t3_tx_idle", int'(m_tx), 1);

        // 4: tx_enable dropped mid-frame with three words queued
        do_reset(2'd0);
        r0 = rd_cnt; f0 = n_frames; s0 = n_starts;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        en = 1'b1;
        wait_starts(s0 + 1);
        step(14);
        en = 1'b0;
        wait_frames(f0 + 1);
        step(60);
        chk("t4_rd_while_disabled", rd_cnt - r0, 1);
        chk("t4_starts_while_disabled", n_starts - s0, 1);
        chk("t4_busy_idle", int'(m_busy), 0);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_pop_after_enable", int'(m_rd), 1);
        wait_frames(f0 + 3);
        step(10);
        chk("t4_rd_total", rd_cnt - r0, 3);
        chk("t4_queue_drained", exp_q.size(), 0);

        // 5: reset during data bit 4
        do_reset(2'd0);
        r0 = rd_cnt; f0 = n_frames; s0 = n_starts;
        push(8'h00);
        push(8'h3C);
        en = 1'b1;
        wait_starts(s0 + 1);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_tx_before_reset", int'(m_tx), 0);
        rst_n = 1'b0;
        #1;
        chk("t5_tx_async_high", int'(m_tx), 1);
        step(2);
        rst_n = 1'b1;
        #1;
        chk("t5_busy_after_release", int'(m_busy), 0);
        chk("t5_rd_after_release", int'(m_rd), 0);
        wait_frames(f0 + 1);
        step(10);
        chk("t5_starts", n_starts - s0, 2);
        chk("t5_rd_pulses", rd_cnt - r0, 2);
        chk("t5_queue_drained", exp_q.size(), 0);

        // 6: two stop bits, FIFO empties
        do_reset(2'd2);
        r0 = rd_cnt; f0 = n_frames; d0 = n_done;
        push(8'hFF);
        en = 1'b1;
        wait_frames(f0 + 1);
        step(30);
        chk("t6_done_pulses", n_done - d0, 1);
        chk("t6_rd_pulses", rd_cnt - r0, 1);
        chk("t6_busy_idle", int'(m_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
